// File: rtl/fetch_queue_ctrl_if.sv
// -----------------------------------------------------------------------------
// fetch_queue_ctrl_if
// Fetch-to-decode handshake bundle between the instruction-fetch controller
// and the IF/ID pipeline register.
//
// Signals:
//   id_valid  head entry of the prefetch queue is valid for decode
//   id_ready  decode accepts the head entry this cycle
//   id_pc     PC of the head entry
//   id_instr  instruction word of the head entry
//
// Modports:
//   master  fetch side (drives valid/pc/instr, samples ready)
//   slave   decode side (samples valid/pc/instr, drives ready)
// -----------------------------------------------------------------------------
interface fetch_queue_ctrl_if;

   logic        id_valid;
   logic        id_ready;
   logic [31:0] id_pc;
   logic [31:0] id_instr;

   modport master (
      output id_valid,
      output id_pc,
      output id_instr,
      input  id_ready
   );

   modport slave (
      input  id_valid,
      input  id_pc,
      input  id_instr,
      output id_ready
   );

endinterface

// File: rtl/fetch_queue_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_queue_ctrl
// Instruction-fetch controller. Drives the combinational instruction memory
// from an internal fetch PC, buffers fetched {pc, instr} pairs in a small
// circular prefetch queue and hands them to decode over a valid/ready
// handshake. Decode stalls are absorbed by the queue (the PC holds once the
// queue is full, nothing is refetched). A redirect flushes the queue and
// restarts fetch at the word-aligned target.
//
// Parameters:
//   RESET_PC  first fetch address after reset (word aligned)
//   DEPTH     prefetch queue entries (power of two, >= 2)
//   CW        width of the occupancy count
//
// Ports:
//   clk             system clock, rising edge
//   rst             asynchronous, active-low reset
//   fetch_en        1 = fetch allowed; 0 = hold PC, push nothing
//   imem_addr       instruction memory address (registered fetch PC)
//   imem_rdata      instruction memory read data, combinational from imem_addr
//   redirect_valid  branch/jump redirect request (single-cycle pulse)
//   redirect_pc     redirect target
//   id_bus          decode handshake (id_valid/id_ready/id_pc/id_instr)
//   q_count         current queue occupancy
// -----------------------------------------------------------------------------
module fetch_queue_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 4,
   parameter int          CW       = $clog2(DEPTH + 1)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      fetch_en,
   output logic [31:0]               imem_addr,
   input  logic [31:0]               imem_rdata,
   input  logic                      redirect_valid,
   input  logic [31:0]               redirect_pc,
   fetch_queue_ctrl_if.master        id_bus,
   output logic [CW-1:0]             q_count
);

   localparam int PW = $clog2(DEPTH);

   logic [31:0]   fetch_pc;
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [CW-1:0] count;
   logic [31:0]   q_pc    [DEPTH];
   logic [31:0]   q_instr [DEPTH];

   logic          full;
   logic          head_valid;
   logic          pop;
   logic          push;

   // Target low bits are dropped on redirect; fetch is always word aligned.
   logic          unused_redirect_lo;
   assign unused_redirect_lo = ^redirect_pc[1:0];

   // Handshake decode. The redirect mask on head_valid keeps decode from
   // consuming a wrong-path word in the redirect cycle, and it also
   // suppresses pop, so a redirect edge never moves rd_ptr or count.
   always_comb begin
      full       = (count == CW'(DEPTH));
      head_valid = (count != '0) && !redirect_valid;
      pop        = head_valid && id_bus.id_ready;
      // Writing into a full queue is only legal when the head leaves the
      // same cycle; the freed slot is exactly the one wr_ptr points at.
      push       = fetch_en && !redirect_valid && (!full || pop);
   end

   assign imem_addr       = fetch_pc;
   assign q_count         = count;
   assign id_bus.id_valid = head_valid;
   assign id_bus.id_pc    = q_pc[rd_ptr];
   assign id_bus.id_instr = q_instr[rd_ptr];

   // Queue storage is reset as well so id_pc/id_instr read 0 during reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fetch_pc <= RESET_PC;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            q_pc[i]    <= '0;
            q_instr[i] <= '0;
         end
      end else if (redirect_valid) begin
         fetch_pc <= {redirect_pc[31:2], 2'b00};
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
      end else begin
         if (push) begin
            q_pc[wr_ptr]    <= fetch_pc;
            q_instr[wr_ptr] <= imem_rdata;
            wr_ptr          <= wr_ptr + PW'(1);
            fetch_pc        <= fetch_pc + 32'd4;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Last PC handed to decode since the most recent redirect/reset; used
   // only to check that deliveries stay in sequential PC order.
   logic          seq_vld;
   logic [31:0]   seq_pc;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         seq_vld <= 1'b0;
         seq_pc  <= '0;
      end else if (redirect_valid) begin
         seq_vld <= 1'b0;
      end else if (pop) begin
         seq_vld <= 1'b1;
         seq_pc  <= id_bus.id_pc;
      end
   end

   a_count_max : assert property (@(posedge clk) disable iff (!rst)
      count <= CW'(DEPTH));

   a_no_overwrite : assert property (@(posedge clk) disable iff (!rst)
      (push && full) |-> pop);

   a_pc_sequence : assert property (@(posedge clk) disable iff (!rst)
      (pop && seq_vld) |-> (id_bus.id_pc == seq_pc + 32'd4));

endmodule

// File: tb/tb_fetch_queue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fetch_queue_ctrl
// Self-checking bench for fetch_queue_ctrl: reset checks, a table of directed
// cycle vectors, hand-written redirect / async-reset sequences and a random
// phase, all compared against a queue-based reference model.
// -----------------------------------------------------------------------------
module tb_fetch_queue_ctrl;

   localparam int DEPTH = 4;
   localparam int CW    = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic          fetch_en;
   logic [31:0]   imem_addr;
   logic [31:0]   imem_rdata;
   logic          redirect_valid;
   logic [31:0]   redirect_pc;
   logic [CW-1:0] q_count;

   fetch_queue_ctrl_if ibus ();

   fetch_queue_ctrl #(
      .RESET_PC (32'h0000_0000),
      .DEPTH    (DEPTH),
      .CW       (CW)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .fetch_en       (fetch_en),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .id_bus         (ibus.master),
      .q_count        (q_count)
   );

   always #5 clk = ~clk;

   // Combinational instruction memory, 32 words indexed by addr[6:2].
   logic [31:0] imem [32];
   assign imem_rdata = imem[imem_addr[6:2]];

   function automatic logic [31:0] word(input logic [31:0] a);
      return imem[a[6:2]];
   endfunction

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference model: ordered list of fetched {pc, instr} and the fetch PC.
   typedef struct {
      logic [31:0] pc;
      logic [31:0] ins;
   } ent_t;

   ent_t        mq[$];
   logic [31:0] mpc;

   logic          last_v;
   logic [31:0]   last_pc;
   logic [31:0]   last_in;
   logic [CW-1:0] last_cnt;
   logic [31:0]   last_addr;

   task automatic model_reset();
      mq.delete();
      mpc = 32'h0000_0000;
   endtask

   // Drive one cycle of inputs, compare outputs against the model, advance
   // the model as the clock edge will, then move past the edge.
   task automatic step(input logic fe, input logic rv, input logic [31:0] rpc, input logic rdy);
      int   sz;
      logic ev;
      logic pop;
      ent_t e;
      fetch_en       = fe;
      redirect_valid = rv;
      redirect_pc    = rpc;
      ibus.id_ready  = rdy;
      #1;
      sz = mq.size();
      ev = (sz != 0) && !rv;
      last_v    = ibus.id_valid;
      last_pc   = ibus.id_pc;
      last_in   = ibus.id_instr;
      last_cnt  = q_count;
      last_addr = imem_addr;
      chk("id_valid", {31'd0, ibus.id_valid}, {31'd0, ev});
      chk("q_count", {29'd0, q_count}, sz);
      chk("imem_addr", imem_addr, mpc);
      if (ev) begin
         chk("id_pc", ibus.id_pc, mq[0].pc);
         chk("id_instr", ibus.id_instr, mq[0].ins);
      end
      pop = ev && rdy;
      if (rv) begin
         mq.delete();
         mpc = {rpc[31:2], 2'b00};
      end else begin
         if (pop) void'(mq.pop_front());
         if (fe && (sz < DEPTH || pop)) begin
            e.pc  = mpc;
            e.ins = word(mpc);
            mq.push_back(e);
            mpc = mpc + 32'd4;
         end
      end
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic          fe;
      logic          rv;
      logic [31:0]   rpc;
      logic          rdy;
      logic          ev;
      logic [31:0]   epc;
      logic [CW-1:0] ecnt;
      logic [31:0]   eaddr;
   } vec_t;

   function automatic vec_t mk(input logic fe, input logic rv, input logic [31:0] rpc,
                               input logic rdy, input logic ev, input logic [31:0] epc,
                               input logic [CW-1:0] ecnt, input logic [31:0] eaddr);
      vec_t v;
      v.fe = fe; v.rv = rv; v.rpc = rpc; v.rdy = rdy;
      v.ev = ev; v.epc = epc; v.ecnt = ecnt; v.eaddr = eaddr;
      return v;
   endfunction

   vec_t tv [18];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bit found;

      // Directed vectors from reset release: fe, rv, rpc, rdy | valid, pc, count, addr
      tv[0]  = mk(1, 0, 32'h00, 1, 0, 32'h00, 0, 32'h00);
      tv[1]  = mk(1, 0, 32'h00, 1, 1, 32'h00, 1, 32'h04);
      tv[2]  = mk(1, 0, 32'h00, 1, 1, 32'h04, 1, 32'h08);
      tv[3]  = mk(1, 0, 32'h00, 1, 1, 32'h08, 1, 32'h0C);
      tv[4]  = mk(1, 0, 32'h00, 0, 1, 32'h0C, 1, 32'h10);
      tv[5]  = mk(1, 0, 32'h00, 0, 1, 32'h0C, 2, 32'h14);
      tv[6]  = mk(1, 0, 32'h00, 0, 1, 32'h0C, 3, 32'h18);
      tv[7]  = mk(1, 0, 32'h00, 0, 1, 32'h0C, 4, 32'h1C);
      tv[8]  = mk(1, 0, 32'h00, 1, 1, 32'h0C, 4, 32'h1C);
      tv[9]  = mk(1, 0, 32'h00, 1, 1, 32'h10, 4, 32'h20);
      tv[10] = mk(1, 1, 32'h13, 1, 0, 32'h00, 4, 32'h24);
      tv[11] = mk(1, 0, 32'h00, 1, 0, 32'h00, 0, 32'h10);
      tv[12] = mk(1, 0, 32'h00, 1, 1, 32'h10, 1, 32'h14);
      tv[13] = mk(0, 0, 32'h00, 1, 1, 32'h14, 1, 32'h18);
      tv[14] = mk(0, 0, 32'h00, 1, 0, 32'h00, 0, 32'h18);
      tv[15] = mk(0, 0, 32'h00, 1, 0, 32'h00, 0, 32'h18);
      tv[16] = mk(1, 0, 32'h00, 1, 0, 32'h00, 0, 32'h18);
      tv[17] = mk(1, 0, 32'h00, 1, 1, 32'h18, 1, 32'h1C);

      for (int i = 0; i < 32; i++) imem[i] = 32'h5A00_0000 | (i << 2);
      imem[0]  = 32'h00a00093;
      imem[1]  = 32'h01400113;
      imem[2]  = 32'h002081b3;
      imem[14] = 32'hfca104e3;

      // Reset state
      rst            = 1'b0;
      fetch_en       = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      ibus.id_ready  = 1'b1;
      repeat (3) @(posedge clk);
      #2;
      chk("rst_id_valid", {31'd0, ibus.id_valid}, 32'd0);
      chk("rst_id_pc", ibus.id_pc, 32'd0);
      chk("rst_id_instr", ibus.id_instr, 32'd0);
      chk("rst_q_count", {29'd0, q_count}, 32'd0);
      chk("rst_imem_addr", imem_addr, 32'd0);
      model_reset();
      @(negedge clk);
      rst = 1'b1;

      // Table-driven directed vectors
      for (int i = 0; i < 18; i++) begin
         step(tv[i].fe, tv[i].rv, tv[i].rpc, tv[i].rdy);
         chk($sformatf("tv%0d_valid", i), {31'd0, last_v}, {31'd0, tv[i].ev});
         chk($sformatf("tv%0d_count", i), {29'd0, last_cnt}, {29'd0, tv[i].ecnt});
         chk($sformatf("tv%0d_addr", i), last_addr, tv[i].eaddr);
         if (tv[i].ev) begin
            chk($sformatf("tv%0d_pc", i), last_pc, tv[i].epc);
            chk($sformatf("tv%0d_instr", i), last_in, word(tv[i].epc));
         end
      end

      // Async reset mid-stream with three entries queued
      step(1, 0, 32'h0, 0);
      step(1, 0, 32'h0, 0);
      chk("pre_arst_count", {29'd0, q_count}, 32'd3);
      #2;
      rst = 1'b0;
      #1;
      chk("arst_id_valid", {31'd0, ibus.id_valid}, 32'd0);
      chk("arst_id_pc", ibus.id_pc, 32'd0);
      chk("arst_id_instr", ibus.id_instr, 32'd0);
      chk("arst_q_count", {29'd0, q_count}, 32'd0);
      chk("arst_imem_addr", imem_addr, 32'd0);
      model_reset();
      @(negedge clk);
      rst = 1'b1;
      step(1, 0, 32'h0, 1);
      step(1, 0, 32'h0, 1);
      chk("arst_resume_pc", last_pc, 32'h00);
      chk("arst_resume_instr", last_in, 32'h00a00093);

      // Run to PC 0x38 and redirect back to 0
      found = 1'b0;
      for (int c = 0; c < 40; c++) begin
         if (ibus.id_valid && ibus.id_pc == 32'h38) begin
            found = 1'b1;
            break;
         end
         step(1, 0, 32'h0, 1);
      end
      chk("seek_0x38", {31'd0, found}, 32'd1);
      if (found) chk("head_0x38_instr", ibus.id_instr, 32'hfca104e3);
      step(1, 1, 32'h0, 1);
      chk("redir_cycle_valid", {31'd0, last_v}, 32'd0);
      step(1, 0, 32'h0, 1);
      chk("redir_next_valid", {31'd0, last_v}, 32'd0);
      step(1, 0, 32'h0, 1);
      chk("redir_target_valid", {31'd0, last_v}, 32'd1);
      chk("redir_target_pc", last_pc, 32'h00);
      chk("redir_target_instr", last_in, 32'h00a00093);

      // Randomized traffic against the model
      for (int c = 0; c < 500; c++) begin
         logic        rv;
         logic [31:0] rpc;
         rv = ($urandom_range(0, 15) == 0);
         if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
         else                           rpc = 32'($urandom_range(0, 127));
         step($urandom_range(0, 4) != 0, rv, rpc, $urandom_range(0, 2) != 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_queue_ctrl.md
Name: fetch_queue_ctrl

Overview:
Instruction-fetch controller that sequences the combinational instruction memory (word-indexed by address bits [6:2]) and buffers fetched words in a small prefetch queue. It feeds the decode stage through a valid/ready handshake. It absorbs decode stalls without refetching. On a branch/jump redirect it flushes the queue and restarts fetch at the target PC. It sits between the instruction memory and the IF/ID pipeline register.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset (word aligned)
DEPTH, 4, prefetch queue entries; power of two, >= 2
CW, $clog2(DEPTH+1), width of occupancy count

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
fetch_en  in  1  1 = fetch allowed; 0 = hold PC, push nothing (queue still drains)
imem_addr  out  32  address to instruction memory; equals internal fetch PC
imem_rdata  in  32  instruction memory read data, combinational from imem_addr, same cycle
redirect_valid  in  1  branch/jump redirect request (single-cycle pulse)
redirect_pc  in  32  redirect target
id_valid  out  1  head entry valid for decode
id_ready  in  1  decode accepts head this cycle
id_pc  out  32  PC of head entry
id_instr  out  32  instruction of head entry
q_count  out  CW  current queue occupancy

Behaviour:
- State: fetch PC register; DEPTH-entry circular queue of {pc[31:0], instr[31:0]}; rd_ptr and wr_ptr, each log2(DEPTH) bits wide and wrapping modulo DEPTH; count register.
- Reset (rst=0, async, any time): fetch PC <= RESET_PC; ptrs <= 0; count <= 0; all queue storage <= 0. Outputs during and after reset: id_valid=0, id_pc=0, id_instr=0, q_count=0, imem_addr=RESET_PC. Reset mid-operation discards all queued entries.
- imem_addr = fetch PC. It is purely registered and has no combinational path from any input.
- pop = id_valid & id_ready.
- push = fetch_en & ~redirect_valid & (count < DEPTH | pop).
  - Push while full is legal only with a same-cycle pop.
- On push: queue[wr_ptr] <= {fetch PC, imem_rdata}; wr_ptr++; fetch PC <= fetch PC + 4.
  - PC arithmetic is 32-bit modulo 2^32.
  - Memory-index wrap at 128 bytes is the memory's concern. The controller does not wrap.
- On pop: rd_ptr++.
- count update:
  - push & ~pop: +1
  - pop & ~push: -1
  - both or neither: unchanged
- id_valid = (count != 0) & ~redirect_valid. The combinational mask guarantees decode never consumes a stale wrong-path word in the redirect cycle.
- id_pc/id_instr = queue[rd_ptr] fields. Their values are don't-care when id_valid=0, except during reset, when they are 0.
- Redirect (highest priority, on the clock edge where redirect_valid=1):
  - ptrs <= 0 and count <= 0.
  - fetch PC <= {redirect_pc[31:2], 2'b00}; misaligned low bits are dropped.
  - No push and no pop occur that edge, regardless of fetch_en/id_ready.
- Latency:
  - The first push occurs on the first rising edge after rst deasserts, if fetch_en=1. id_valid rises the following cycle.
  - After a redirect edge, the target instruction is pushed on the next edge and is visible on id_* one cycle later: 2 cycles redirect-to-valid.
- Steady state with id_ready=1 and fetch_en=1: count holds at 1, and one instruction per cycle is delivered in PC order.
- Stall (id_ready=0): the queue fills to DEPTH, then fetch PC holds. There is no over-write and no re-fetch. On resume, order is preserved.
- fetch_en=0: fetch PC frozen and no push. Queued entries continue to drain.
- Assertions:
  - count never exceeds DEPTH.
  - push never occurs when count==DEPTH without pop.
  - id_pc sequence between redirects increases by 4.

Test Plan:
- Reset release, fetch_en=1, id_ready=1, memory preloaded with the standard test program -> id_valid rises cycle 2. Deliveries: id_pc=0x00/id_instr=0x00a00093, then 0x04/0x01400113, then 0x08/0x002081b3, one per cycle. q_count stays 1.
- Hold id_ready=0 for 8 cycles from reset -> q_count climbs to 4 and stops; imem_addr holds 0x10. Release id_ready -> instructions delivered in order 0x00..0x0C, then 0x10 onward with no gap or duplicate.
- At id_pc=0x38 (instr 0xfca104e3), pulse redirect_valid with redirect_pc=0x00 -> id_valid=0 that cycle and the next. The next delivered is id_pc=0x00, instr 0x00a00093. No entry from 0x3C/0x40 ever appears.
- Redirect with redirect_pc=0x0000_0013 while queue full and id_ready=1 -> fetch restarts at 0x10. q_count=0 after the edge. No pop is counted that edge.
- Assert rst low asynchronously mid-stream with q_count=3 -> outputs drop to 0 immediately without a clock edge and imem_addr=0. After release, fetch resumes from 0x00.
- Toggle fetch_en=0 for 3 cycles with id_ready=1 -> queue drains to 0, imem_addr frozen. On re-enable, the next pushed PC is the frozen value and sequence continuity holds.
